// File: rtl/core_mem_arbiter.sv
// Arbiter sharing one synchronous SRAM port between instruction fetch (IF) and
// load/store (LS). LS wins contention until IF has waited LS_BURST_MAX LS grants;
// every grant gets its response exactly one cycle later, one access per cycle.
module core_mem_arbiter #(
  parameter int unsigned MEM_ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned LS_BURST_MAX   = 3
) (
  input  logic                      clk,
  input  logic                      rst_n,
  // Instruction fetch port
  input  logic                      if_req_i,
  input  logic [MEM_ADDR_WIDTH-1:0] if_addr_i,
  output logic                      if_gnt_o,
  output logic                      if_rvalid_o,
  output logic [DATA_WIDTH-1:0]     if_rdata_o,
  // Load/store port
  input  logic                      ls_req_i,
  input  logic                      ls_we_i,
  input  logic [MEM_ADDR_WIDTH-1:0] ls_addr_i,
  input  logic [DATA_WIDTH-1:0]     ls_wdata_i,
  output logic                      ls_gnt_o,
  output logic                      ls_rvalid_o,
  output logic [DATA_WIDTH-1:0]     ls_rdata_o,
  // Memory port
  output logic                      mem_req_o,
  output logic                      mem_we_o,
  output logic [MEM_ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0]     mem_wdata_o,
  input  logic [DATA_WIDTH-1:0]     mem_rdata_i,
  output logic                      stall_o
);

  localparam int unsigned CntWidth = (LS_BURST_MAX < 1) ? 1 : $clog2(LS_BURST_MAX + 1);
  localparam logic [CntWidth-1:0] CntMax = CntWidth'(LS_BURST_MAX);

  typedef enum logic [1:0] {
    StIdle,
    StRespIf,
    StRespLs
  } state_e;

  state_e              state_q, state_d;
  logic [CntWidth-1:0] starve_cnt_q, starve_cnt_d;
  logic                ls_we_q, ls_we_d;

  // Grant selection; grants are held low while reset is asserted.
  always_comb begin
    if_gnt_o = 1'b0;
    ls_gnt_o = 1'b0;
    if (rst_n) begin
      if (if_req_i && (!ls_req_i || (starve_cnt_q == CntMax))) begin
        if_gnt_o = 1'b1;
      end else if (ls_req_i) begin
        ls_gnt_o = 1'b1;
      end
    end
  end

  // Memory port mux driven from the granted requester, zero when idle.
  always_comb begin
    mem_req_o   = if_gnt_o | ls_gnt_o;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if (if_gnt_o) begin
      mem_addr_o = if_addr_i;
    end else if (ls_gnt_o) begin
      mem_we_o    = ls_we_i;
      mem_addr_o  = ls_addr_i;
      mem_wdata_o = ls_wdata_i;
    end
    stall_o = (if_req_i & ~if_gnt_o) | (ls_req_i & ~ls_gnt_o);
  end

  // Starvation counter: counts LS grants taken while IF is waiting.
  always_comb begin
    starve_cnt_d = '0;
    if (ls_gnt_o && if_req_i) begin
      starve_cnt_d = (starve_cnt_q == CntMax) ? CntMax : starve_cnt_q + 1'b1;
    end
  end

  // Response FSM next state and response outputs.
  always_comb begin
    state_d = StIdle;
    ls_we_d = 1'b0;
    if (if_gnt_o) begin
      state_d = StRespIf;
    end else if (ls_gnt_o) begin
      state_d = StRespLs;
      ls_we_d = ls_we_i;
    end

    if_rvalid_o = 1'b0;
    if_rdata_o  = '0;
    ls_rvalid_o = 1'b0;
    ls_rdata_o  = '0;
    unique case (state_q)
      StRespIf: begin
        if_rvalid_o = 1'b1;
        if_rdata_o  = mem_rdata_i;
      end
      StRespLs: begin
        ls_rvalid_o = 1'b1;
        // Stores complete with zero data.
        ls_rdata_o  = ls_we_q ? '0 : mem_rdata_i;
      end
      default: ;
    endcase
  end

  // State registers; reset drops any in-flight response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      starve_cnt_q <= '0;
      ls_we_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      ls_we_q      <= ls_we_d;
    end
  end

endmodule

// File: tb/tb_core_mem_arbiter.sv
// Self-checking bench for core_mem_arbiter: directed scenarios plus random traffic
// checked against a transaction-level model of the arbitration rules.
module tb_core_mem_arbiter;

  localparam int unsigned AW = 10;
  localparam int unsigned DW = 32;
  localparam int unsigned BM = 3;
  localparam int unsigned VW = 7 + AW + 3 * DW;

  logic          clk;
  logic          rst_n;
  logic          if_req_i;
  logic [AW-1:0] if_addr_i;
  logic          if_gnt_o;
  logic          if_rvalid_o;
  logic [DW-1:0] if_rdata_o;
  logic          ls_req_i;
  logic          ls_we_i;
  logic [AW-1:0] ls_addr_i;
  logic [DW-1:0] ls_wdata_i;
  logic          ls_gnt_o;
  logic          ls_rvalid_o;
  logic [DW-1:0] ls_rdata_o;
  logic          mem_req_o;
  logic          mem_we_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_wdata_o;
  logic [DW-1:0] mem_rdata_i;
  logic          stall_o;

  int n_cmp  = 0;
  int n_fail = 0;

  core_mem_arbiter #(
    .MEM_ADDR_WIDTH(AW),
    .DATA_WIDTH    (DW),
    .LS_BURST_MAX  (BM)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .if_req_i   (if_req_i),
    .if_addr_i  (if_addr_i),
    .if_gnt_o   (if_gnt_o),
    .if_rvalid_o(if_rvalid_o),
    .if_rdata_o (if_rdata_o),
    .ls_req_i   (ls_req_i),
    .ls_we_i    (ls_we_i),
    .ls_addr_i  (ls_addr_i),
    .ls_wdata_i (ls_wdata_i),
    .ls_gnt_o   (ls_gnt_o),
    .ls_rvalid_o(ls_rvalid_o),
    .ls_rdata_o (ls_rdata_o),
    .mem_req_o  (mem_req_o),
    .mem_we_o   (mem_we_o),
    .mem_addr_o (mem_addr_o),
    .mem_wdata_o(mem_wdata_o),
    .mem_rdata_i(mem_rdata_i),
    .stall_o    (stall_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: number of LS grants IF has been waiting through, and the
  // access (if any) whose response is due in the current cycle.
  int   m_wait     = 0;
  bit   m_resp_if  = 1'b0;
  bit   m_resp_ls  = 1'b0;
  bit   m_resp_st  = 1'b0;
  logic [VW-1:0] e_vec;

  // Returns {if_gnt, ls_gnt} according to the priority rules.
  function automatic logic [1:0] gnt_rule();
    if (!rst_n) return 2'b00;
    if (if_req_i && (!ls_req_i || m_wait >= BM)) return 2'b10;
    if (ls_req_i) return 2'b01;
    return 2'b00;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_wait    <= 0;
      m_resp_if <= 1'b0;
      m_resp_ls <= 1'b0;
      m_resp_st <= 1'b0;
    end else begin
      m_resp_if <= gnt_rule() == 2'b10;
      m_resp_ls <= gnt_rule() == 2'b01;
      m_resp_st <= ls_we_i;
      if (if_req_i && gnt_rule() == 2'b01) m_wait <= (m_wait + 1 > BM) ? BM : m_wait + 1;
      else m_wait <= 0;
    end
  end

  function automatic logic [VW-1:0] obs_vec();
    return {if_gnt_o, ls_gnt_o, mem_req_o, mem_we_o, stall_o, if_rvalid_o, ls_rvalid_o,
            mem_addr_o, mem_wdata_o, if_rdata_o, ls_rdata_o};
  endfunction

  function automatic void predict();
    logic [1:0]    g;
    logic          ifv, lsv;
    logic [AW-1:0] addr;
    logic [DW-1:0] wd, ifd, lsd;
    g    = gnt_rule();
    addr = g[1] ? if_addr_i : (g[0] ? ls_addr_i : '0);
    wd   = g[0] ? ls_wdata_i : '0;
    ifv  = rst_n && m_resp_if;
    lsv  = rst_n && m_resp_ls;
    ifd  = ifv ? mem_rdata_i : '0;
    lsd  = (lsv && !m_resp_st) ? mem_rdata_i : '0;
    e_vec = {g[1], g[0], g[1] | g[0], g[0] & ls_we_i,
             (if_req_i & ~g[1]) | (ls_req_i & ~g[0]), ifv, lsv, addr, wd, ifd, lsd};
  endfunction

  // Applies one cycle of inputs at the falling edge, then predicts the outputs.
  task automatic drive(input logic ir, input logic [AW-1:0] ia, input logic lr, input logic lw,
                       input logic [AW-1:0] la, input logic [DW-1:0] lwd,
                       input logic [DW-1:0] rd);
    @(negedge clk);
    if_req_i    = ir;
    if_addr_i   = ia;
    ls_req_i    = lr;
    ls_we_i     = lw;
    ls_addr_i   = la;
    ls_wdata_i  = lwd;
    mem_rdata_i = rd;
    #1;
    predict();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    if_req_i = 1'b1; if_addr_i = 10'h3; ls_req_i = 1'b1; ls_we_i = 1'b1;
    ls_addr_i = 10'h5; ls_wdata_i = 32'h55; mem_rdata_i = 32'h77;
    repeat (2) @(posedge clk);
    #2;
    n_cmp++;
    if ({if_gnt_o, ls_gnt_o, mem_req_o, mem_we_o, if_rvalid_o, ls_rvalid_o, stall_o} !== 7'b0000001) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b expected %b",
               {if_gnt_o, ls_gnt_o, mem_req_o, mem_we_o, if_rvalid_o, ls_rvalid_o, stall_o},
               7'b0000001);
    end
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 10'h8, 1'b0, 1'b0, '0, '0, 32'h0);
    n_cmp++;
    if ({if_gnt_o, mem_req_o, mem_addr_o} !== {1'b1, 1'b1, 10'h8}) begin
      n_fail++;
      $display("FAIL first_grant_after_reset: got %h expected %h",
               {if_gnt_o, mem_req_o, mem_addr_o}, {1'b1, 1'b1, 10'h8});
    end
    drive(1'b0, '0, 1'b0, 1'b0, '0, '0, 32'h0);
  endtask

  task automatic test_if_fetch();
    drive(1'b1, 10'h004, 1'b0, 1'b0, '0, '0, 32'h1111);
    n_cmp++;
    if ({if_gnt_o, mem_we_o, mem_addr_o, if_rvalid_o} !== {1'b1, 1'b0, 10'h004, 1'b0}) begin
      n_fail++;
      $display("FAIL if_fetch_grant: got %h expected %h",
               {if_gnt_o, mem_we_o, mem_addr_o, if_rvalid_o}, {1'b1, 1'b0, 10'h004, 1'b0});
    end
    drive(1'b0, '0, 1'b0, 1'b0, '0, '0, 32'hDEADBEEF);
    n_cmp++;
    if ({if_rvalid_o, if_rdata_o, ls_rvalid_o} !== {1'b1, 32'hDEADBEEF, 1'b0}) begin
      n_fail++;
      $display("FAIL if_fetch_resp: got %h expected %h",
               {if_rvalid_o, if_rdata_o, ls_rvalid_o}, {1'b1, 32'hDEADBEEF, 1'b0});
    end
  endtask

  task automatic test_contention();
    drive(1'b1, 10'h20, 1'b1, 1'b0, 10'h30, 32'h0, 32'h0);
    n_cmp++;
    if ({ls_gnt_o, if_gnt_o, stall_o, mem_addr_o} !== {1'b1, 1'b0, 1'b1, 10'h30}) begin
      n_fail++;
      $display("FAIL contention_ls_wins: got %h expected %h",
               {ls_gnt_o, if_gnt_o, stall_o, mem_addr_o}, {1'b1, 1'b0, 1'b1, 10'h30});
    end
    drive(1'b1, 10'h20, 1'b0, 1'b0, '0, '0, 32'hCAFE0001);
    n_cmp++;
    if ({if_gnt_o, stall_o, ls_rvalid_o, ls_rdata_o} !== {1'b1, 1'b0, 1'b1, 32'hCAFE0001}) begin
      n_fail++;
      $display("FAIL contention_if_next: got %h expected %h",
               {if_gnt_o, stall_o, ls_rvalid_o, ls_rdata_o}, {1'b1, 1'b0, 1'b1, 32'hCAFE0001});
    end
    drive(1'b0, '0, 1'b0, 1'b0, '0, '0, 32'h0);
  endtask

  task automatic test_starvation();
    drive(1'b0, '0, 1'b0, 1'b0, '0, '0, 32'h0);
    for (int c = 1; c <= 5; c++) begin
      drive(1'b1, 10'h44, 1'b1, 1'b0, 10'h88, 32'h0, 32'h0);
      n_cmp++;
      // Three LS grants, then IF, then LS again since the count restarted.
      if ({if_gnt_o, ls_gnt_o} !== ((c == 4) ? 2'b10 : 2'b01)) begin
        n_fail++;
        $display("FAIL starvation_cycle%0d: got %b expected %b", c, {if_gnt_o, ls_gnt_o},
                 (c == 4) ? 2'b10 : 2'b01);
      end
    end
    drive(1'b0, '0, 1'b0, 1'b0, '0, '0, 32'h0);
  endtask

  task automatic test_store();
    drive(1'b0, '0, 1'b1, 1'b1, 10'h010, 32'h12345678, 32'h0);
    n_cmp++;
    if ({ls_gnt_o, mem_we_o, mem_addr_o, mem_wdata_o} !== {1'b1, 1'b1, 10'h010, 32'h12345678}) begin
      n_fail++;
      $display("FAIL store_issue: got %h expected %h",
               {ls_gnt_o, mem_we_o, mem_addr_o, mem_wdata_o}, {1'b1, 1'b1, 10'h010, 32'h12345678});
    end
    drive(1'b0, '0, 1'b0, 1'b0, '0, '0, 32'hFFFF0000);
    n_cmp++;
    if ({ls_rvalid_o, ls_rdata_o, if_rvalid_o} !== {1'b1, 32'h0, 1'b0}) begin
      n_fail++;
      $display("FAIL store_resp: got %h expected %h",
               {ls_rvalid_o, ls_rdata_o, if_rvalid_o}, {1'b1, 32'h0, 1'b0});
    end
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 10'h100, 1'b0, 1'b0, '0, '0, 32'h0);
    n_cmp++;
    if (if_gnt_o !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_if1_grant: got %b expected 1", if_gnt_o);
    end
    drive(1'b0, '0, 1'b1, 1'b0, 10'h104, 32'h0, 32'hA0A0A0A0);
    n_cmp++;
    if ({ls_gnt_o, if_rvalid_o, if_rdata_o, ls_rvalid_o} !== {1'b1, 1'b1, 32'hA0A0A0A0, 1'b0}) begin
      n_fail++;
      $display("FAIL b2b_ls_grant_if_resp: got %h expected %h",
               {ls_gnt_o, if_rvalid_o, if_rdata_o, ls_rvalid_o}, {1'b1, 1'b1, 32'hA0A0A0A0, 1'b0});
    end
    drive(1'b1, 10'h108, 1'b0, 1'b0, '0, '0, 32'hB1B1B1B1);
    n_cmp++;
    if ({if_gnt_o, ls_rvalid_o, ls_rdata_o, if_rvalid_o} !== {1'b1, 1'b1, 32'hB1B1B1B1, 1'b0}) begin
      n_fail++;
      $display("FAIL b2b_if2_grant_ls_resp: got %h expected %h",
               {if_gnt_o, ls_rvalid_o, ls_rdata_o, if_rvalid_o}, {1'b1, 1'b1, 32'hB1B1B1B1, 1'b0});
    end
    drive(1'b0, '0, 1'b0, 1'b0, '0, '0, 32'hC2C2C2C2);
    n_cmp++;
    if ({if_rvalid_o, if_rdata_o, ls_rvalid_o} !== {1'b1, 32'hC2C2C2C2, 1'b0}) begin
      n_fail++;
      $display("FAIL b2b_if2_resp: got %h expected %h",
               {if_rvalid_o, if_rdata_o, ls_rvalid_o}, {1'b1, 32'hC2C2C2C2, 1'b0});
    end
  endtask

  task automatic test_reset_mid();
    drive(1'b0, '0, 1'b1, 1'b0, 10'h2A, 32'h0, 32'h0);
    n_cmp++;
    if (ls_gnt_o !== 1'b1) begin
      n_fail++;
      $display("FAIL midreset_grant: got %b expected 1", ls_gnt_o);
    end
    @(posedge clk);
    #2;
    if_req_i = 1'b0; ls_req_i = 1'b0; mem_rdata_i = 32'h5A5A5A5A;
    #1;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (obs_vec() !== {VW{1'b0}}) begin
      n_fail++;
      $display("FAIL midreset_outputs: got %h expected 0", obs_vec());
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_cmp++;
    if ({if_rvalid_o, ls_rvalid_o} !== 2'b00) begin
      n_fail++;
      $display("FAIL midreset_no_rvalid: got %b expected 00", {if_rvalid_o, ls_rvalid_o});
    end
  endtask

  task automatic test_random();
    logic [VW-1:0] o;
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 3) != 0), AW'($urandom), ($urandom_range(0, 2) != 0),
            1'($urandom), AW'($urandom), $urandom, $urandom);
      o = obs_vec();
      n_cmp++;
      if (o !== e_vec) begin
        n_fail++;
        $display("FAIL random_cycle%0d: got %h expected %h", i, o, e_vec);
      end
    end
    drive(1'b0, '0, 1'b0, 1'b0, '0, '0, 32'h0);
  endtask

  initial begin
    test_reset();
    test_if_fetch();
    test_contention();
    test_starvation();
    test_store();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/core_mem_arbiter.md
CORE_MEM_ARBITER -- requirements
Module: core_mem_arbiter

Interface
REQ-001 SHALL have parameter MEM_ADDR_WIDTH, default 10, meaning the memory word-address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, meaning the data bus width.
REQ-003 SHALL have parameter LS_BURST_MAX, default 3, meaning the number of consecutive load/store grants allowed while a fetch request waits.
REQ-004 SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port if_req_i, input, 1 bit: instruction-fetch request.
REQ-007 SHALL have port if_addr_i, input, MEM_ADDR_WIDTH bits: fetch address.
REQ-008 SHALL have port if_gnt_o, output, 1 bit: fetch request accepted this cycle.
REQ-009 SHALL have port if_rvalid_o, output, 1 bit: fetch data valid.
REQ-010 SHALL have port if_rdata_o, output, DATA_WIDTH bits: fetch data.
REQ-011 SHALL have port ls_req_i, input, 1 bit: load/store request from the execution unit's LIS path.
REQ-012 SHALL have port ls_we_i, input, 1 bit: 1 = store, 0 = load.
REQ-013 SHALL have port ls_addr_i, input, MEM_ADDR_WIDTH bits: load/store address.
REQ-014 SHALL have port ls_wdata_i, input, DATA_WIDTH bits: store data.
REQ-015 SHALL have port ls_gnt_o, output, 1 bit: load/store request accepted this cycle.
REQ-016 SHALL have port ls_rvalid_o, output, 1 bit: load data valid or store complete.
REQ-017 SHALL have port ls_rdata_o, output, DATA_WIDTH bits: load data.
REQ-018 SHALL have port mem_req_o, output, 1 bit: memory access strobe.
REQ-019 SHALL have port mem_we_o, output, 1 bit: memory write enable.
REQ-020 SHALL have port mem_addr_o, output, MEM_ADDR_WIDTH bits: memory address.
REQ-021 SHALL have port mem_wdata_o, output, DATA_WIDTH bits: memory write data.
REQ-022 SHALL have port mem_rdata_i, input, DATA_WIDTH bits: synchronous-SRAM read data, valid one cycle after the access.
REQ-023 SHALL have port stall_o, output, 1 bit: asserted when any asserted request is not granted this cycle.

Function
REQ-024 SHALL arbitrate combinationally: at most one grant per cycle, and mem_req_o SHALL equal if_gnt_o OR ls_gnt_o.
REQ-025 SHALL use LS priority by default: when both requesters are active and starve_cnt < LS_BURST_MAX, ls_gnt_o=1 and if_gnt_o=0.
REQ-026 SHALL grant IF instead when both requesters are active and starve_cnt == LS_BURST_MAX.
REQ-027 SHALL keep a starve_cnt register, width clog2(LS_BURST_MAX+1): incremented, saturating at LS_BURST_MAX, on each cycle with ls_gnt_o=1 and if_req_i=1; cleared on any if_gnt_o=1 or when if_req_i=0.
REQ-028 SHALL drive mem_addr_o, mem_we_o and mem_wdata_o from the granted requester's inputs; with no grant, these outputs SHALL be 0.
REQ-029 SHALL hold the mem_we_o=0 condition whenever IF is granted.
REQ-030 SHALL implement a response FSM with states IDLE, RESP_IF and RESP_LS; the next state SHALL be RESP_IF on if_gnt_o, RESP_LS on ls_gnt_o, and IDLE otherwise, evaluated every cycle so accesses may issue back-to-back.
REQ-031 SHALL, in RESP_IF, set if_rvalid_o=1 and if_rdata_o=mem_rdata_i; if_rdata_o SHALL be 0 otherwise.
REQ-032 SHALL, in RESP_LS, set ls_rvalid_o=1; ls_rdata_o SHALL be mem_rdata_i for a load (registered ls_we=0) and 0 for a store.
REQ-033 SHALL give every granted access a latency of exactly one cycle from grant to rvalid.
REQ-034 SHALL make a new grant legal in the same cycle as an rvalid, allowing a throughput of one access per cycle.
REQ-035 SHALL drive stall_o = (if_req_i AND NOT if_gnt_o) OR (ls_req_i AND NOT ls_gnt_o).
REQ-036 SHALL hold requesters' address and data stable until granted; the arbiter SHALL NOT latch any request before its grant.

Reset
REQ-037 SHALL, while rst_n=0, force state IDLE and starve_cnt=0 immediately, independent of clk.
REQ-038 SHALL, while rst_n=0, drive all grants, rvalids, mem_req_o and mem_we_o to 0, with stall_o following REQ-035 using zero grants.
REQ-039 SHALL drop any in-flight response on a reset mid-access, with no rvalid after reset release.
REQ-040 SHALL allow the first grant in the first clock cycle after rst_n rises.

Verification
REQ-041 SHALL be verified with: IF only, if_addr=0x004, mem_rdata=0xDEADBEEF next cycle -> if_gnt=1, mem_we=0, if_rvalid=1 and if_rdata=0xDEADBEEF one cycle later.
REQ-042 SHALL be verified with: IF and LS load in the same cycle -> ls_gnt=1, if_gnt=0, stall_o=1; IF granted next cycle if LS drops.
REQ-043 SHALL be verified with: LS held continuously with IF pending, LS_BURST_MAX=3 -> LS granted 3 cycles, IF granted in cycle 4, starve_cnt back to 0.
REQ-044 SHALL be verified with: store ls_addr=0x010, wdata=0x12345678 -> mem_we=1, mem_wdata=0x12345678, ls_rvalid=1 next cycle with ls_rdata=0.
REQ-045 SHALL be verified with: back-to-back IF, LS, IF grants -> rvalids on consecutive cycles routed to the correct requester.
REQ-046 SHALL be verified with: rst_n pulled low the cycle after a grant -> no rvalid, all outputs 0 asynchronously.
